// File: rtl/mem_copy_dma.sv
// -----------------------------------------------------------------------------
// mem_copy_dma
//
// Memory-to-memory copy engine. A copy request from the core latches a source
// address, a destination address and a byte count. The block then moves the
// data in bursts of up to BURST_MAX words. Each burst is a read into a small
// local word buffer, followed by a write of that buffer to the destination. Only
// one request (read or write) is ever outstanding. Read and write bursts never
// overlap.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   copy_active    start request, sampled only while idle
//   src_addr       byte source address; bits [1:0] ignored
//   dst_addr       byte destination address; bits [1:0] ignored
//   copy_len       byte count; bits [1:0] ignored, words = copy_len[31:2]
//   copy_done      one-cycle completion pulse
//   busy           high whenever the engine is not idle
//   read_request   read burst request (registered)
//   read_address   read burst start address
//   read_len       read burst beats-1
//   read_gnt       read request accepted
//   rvalid         read beat valid
//   read_data      read beat data
//   write_request  write burst request (registered)
//   write_address  write burst start address
//   write_len      write burst beats-1
//   write_gnt      write request accepted
//   wvalid         write beat valid
//   write_data     write beat data
//   wready         write beat accepted
//   write_resp     write burst complete response
// -----------------------------------------------------------------------------
module mem_copy_dma #(
    parameter int BURST_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        copy_active,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [31:0] copy_len,
    output logic        copy_done,
    output logic        busy,
    output logic        read_request,
    output logic [31:0] read_address,
    output logic [3:0]  read_len,
    input  logic        read_gnt,
    input  logic        rvalid,
    input  logic [31:0] read_data,
    output logic        write_request,
    output logic [31:0] write_address,
    output logic [3:0]  write_len,
    input  logic        write_gnt,
    output logic        wvalid,
    output logic [31:0] write_data,
    input  logic        wready,
    input  logic        write_resp
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [31:0] BURST_MAX_W = 32'(BURST_MAX);
    localparam logic [4:0]  BURST_MAX_5 = 5'(BURST_MAX);

    // Burst size for a given number of remaining words: min(words, BURST_MAX).
    function automatic logic [4:0] burst_of(input logic [31:0] words);
        return (words >= BURST_MAX_W) ? BURST_MAX_5 : words[4:0];
    endfunction

    state_t      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] remaining_q, remaining_d;
    logic [4:0]  burst_q, burst_d;
    logic [3:0]  beat_q, beat_d;

    logic        copy_done_q, copy_done_d;
    logic        busy_q, busy_d;
    logic        rd_req_q, rd_req_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [3:0]  rd_len_q, rd_len_d;
    logic        wr_req_q, wr_req_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [3:0]  wr_len_q, wr_len_d;
    logic        wvalid_q, wvalid_d;
    logic [31:0] wdata_q, wdata_d;

    // Local burst buffer. It has no reset, so it can map onto RAM. Its
    // contents are don't-care after a reset.
    logic [31:0] buf_mem [0:BURST_MAX-1];
    logic        buf_we;
    logic [3:0]  buf_rd_idx;

    logic        last_beat;
    assign last_beat = ({1'b0, beat_q} == (burst_q - 5'd1));

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        remaining_d = remaining_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        copy_done_d = 1'b0;
        rd_req_d    = rd_req_q;
        rd_addr_d   = rd_addr_q;
        rd_len_d    = rd_len_q;
        wr_req_d    = wr_req_q;
        wr_addr_d   = wr_addr_q;
        wr_len_d    = wr_len_q;
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;
        buf_we      = 1'b0;
        buf_rd_idx  = 4'd0;

        case (state_q)
            IDLE: begin
                if (copy_active) begin
                    src_d       = src_addr & ~32'h3;
                    dst_d       = dst_addr & ~32'h3;
                    remaining_d = copy_len >> 2;
                    if (remaining_d == 32'd0) begin
                        state_d = DONE;
                    end else begin
                        // The burst size is fixed here, on entry to RD_REQ.
                        state_d   = RD_REQ;
                        burst_d   = burst_of(remaining_d);
                        rd_req_d  = 1'b1;
                        rd_addr_d = src_d;
                        rd_len_d  = 4'(burst_d - 5'd1);
                    end
                end
            end

            RD_REQ: begin
                if (read_gnt) begin
                    rd_req_d = 1'b0;
                    beat_d   = 4'd0;
                    state_d  = RD_DATA;
                end
            end

            RD_DATA: begin
                if (rvalid) begin
                    buf_we = 1'b1;
                    if (last_beat) begin
                        beat_d    = 4'd0;
                        state_d   = WR_REQ;
                        wr_req_d  = 1'b1;
                        wr_addr_d = dst_q;
                        wr_len_d  = 4'(burst_q - 5'd1);
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end

            WR_REQ: begin
                if (write_gnt) begin
                    wr_req_d   = 1'b0;
                    state_d    = WR_DATA;
                    beat_d     = 4'd0;
                    wvalid_d   = 1'b1;
                    // Prefetch the first beat so write_data is a registered
                    // buffer read.
                    buf_rd_idx = 4'd0;
                    wdata_d    = buf_mem[buf_rd_idx];
                end
            end

            WR_DATA: begin
                if (wvalid_q && wready) begin
                    if (last_beat) begin
                        wvalid_d = 1'b0;
                        wdata_d  = 32'd0;
                        beat_d   = 4'd0;
                        state_d  = WR_RESP;
                    end else begin
                        // Advance only on an accepted beat. While wready is
                        // low, the current word stays on write_data.
                        beat_d     = beat_q + 4'd1;
                        buf_rd_idx = beat_q + 4'd1;
                        wdata_d    = buf_mem[buf_rd_idx];
                    end
                end
            end

            WR_RESP: begin
                if (write_resp) begin
                    // Address arithmetic wraps modulo 2^32.
                    src_d       = src_q + {25'd0, burst_q, 2'b00};
                    dst_d       = dst_q + {25'd0, burst_q, 2'b00};
                    remaining_d = remaining_q - {27'd0, burst_q};
                    if (remaining_d == 32'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = RD_REQ;
                        burst_d   = burst_of(remaining_d);
                        rd_req_d  = 1'b1;
                        rd_addr_d = src_d;
                        rd_len_d  = 4'(burst_d - 5'd1);
                    end
                end
            end

            DONE: begin
                // The completion pulse is registered. It appears in the
                // cycle after DONE, as the engine drops back to IDLE.
                copy_done_d = 1'b1;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= 32'd0;
            dst_q       <= 32'd0;
            remaining_q <= 32'd0;
            burst_q     <= 5'd0;
            beat_q      <= 4'd0;
            copy_done_q <= 1'b0;
            busy_q      <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= 32'd0;
            rd_len_q    <= 4'd0;
            wr_req_q    <= 1'b0;
            wr_addr_q   <= 32'd0;
            wr_len_q    <= 4'd0;
            wvalid_q    <= 1'b0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            copy_done_q <= copy_done_d;
            busy_q      <= busy_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            rd_len_q    <= rd_len_d;
            wr_req_q    <= wr_req_d;
            wr_addr_q   <= wr_addr_d;
            wr_len_q    <= wr_len_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
        end
    end

    // Buffer write port. rvalid only lands here while collecting a read burst.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[beat_q] <= read_data;
        end
    end

    assign copy_done     = copy_done_q;
    assign busy          = busy_q;
    assign read_request  = rd_req_q;
    assign read_address  = rd_addr_q;
    assign read_len      = rd_len_q;
    assign write_request = wr_req_q;
    assign write_address = wr_addr_q;
    assign write_len     = wr_len_q;
    assign wvalid        = wvalid_q;
    assign write_data    = wdata_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        copy_active = 1'b0;
    logic [31:0] src_addr = 32'd0;
    logic [31:0] dst_addr = 32'd0;
    logic [31:0] copy_len = 32'd0;
    logic        copy_done;
    logic        busy;
    logic        read_request;
    logic [31:0] read_address;
    logic [3:0]  read_len;
    logic        read_gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] read_data = 32'd0;
    logic        write_request;
    logic [31:0] write_address;
    logic [3:0]  write_len;
    logic        write_gnt = 1'b0;
    logic        wvalid;
    logic [31:0] write_data;
    logic        wready = 1'b0;
    logic        write_resp = 1'b0;

    always #5 clk = ~clk;

    mem_copy_dma #(.BURST_MAX(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .copy_active   (copy_active),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .copy_len      (copy_len),
        .copy_done     (copy_done),
        .busy          (busy),
        .read_request  (read_request),
        .read_address  (read_address),
        .read_len      (read_len),
        .read_gnt      (read_gnt),
        .rvalid        (rvalid),
        .read_data     (read_data),
        .write_request (write_request),
        .write_address (write_address),
        .write_len     (write_len),
        .write_gnt     (write_gnt),
        .wvalid        (wvalid),
        .write_data    (write_data),
        .wready        (wready),
        .write_resp    (write_resp)
    );

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        bit          wr_toggle;
        bit          rv_gaps;
        bit          poke;
        bit          spur;
        bit          do_rst;
        int          gdelay;
        int          exp_bursts;
        logic [31:0] exp_rd2;
        int          exp_done_cyc;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
    } burst_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    burst_t      exp_rd [$];
    burst_t      exp_wr [$];
    logic [31:0] exp_data [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Source memory contents as a pure function of the word address.
    function automatic logic [31:0] src_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // Reference model: the bursts and data words one copy must produce.
    task automatic push_expected(input logic [31:0] src, input logic [31:0] dst,
                                 input logic [31:0] len);
        logic [31:0] s, d, w, b;
        burst_t      bt;
        s = src & ~32'h3;
        d = dst & ~32'h3;
        w = len >> 2;
        while (w != 32'd0) begin
            b = (w > 32'd16) ? 32'd16 : w;
            bt.addr = s; bt.len = 4'(b - 32'd1); exp_rd.push_back(bt);
            bt.addr = d; bt.len = 4'(b - 32'd1); exp_wr.push_back(bt);
            for (int i = 0; i < int'(b); i++) exp_data.push_back(src_word(s + 32'(4 * i)));
            s = s + (b << 2);
            d = d + (b << 2);
            w = w - b;
        end
    endtask

    task automatic idle_inputs();
        copy_active = 1'b0; read_gnt = 1'b0; rvalid = 1'b0; read_data = 32'd0;
        write_gnt = 1'b0; wready = 1'b0; write_resp = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {27'd0, copy_done, busy, read_request, write_request, wvalid}, 32'd0);
        check({tag, "_rd_addr"}, read_address, 32'd0);
        check({tag, "_wr_addr"}, write_address, 32'd0);
        check({tag, "_wdata"}, write_data, 32'd0);
        check({tag, "_lens"}, {24'd0, read_len, write_len}, 32'd0);
    endtask

    task automatic run_vec(input int k);
        vec_t        v;
        int          cyc, done_cnt, done_cyc, rd_bursts, wr_bursts;
        int          rd_left, rd_beat, wr_left, resp_cnt, rgnt_cnt, wgnt_cnt, dn;
        bit          rd_seen, wr_seen, prev_hold, reset_hit, bad;
        burst_t      rd_obs, wr_obs, bt;
        logic [31:0] prev_data, rd2_addr, ed;
        v = vecs[k];
        cyc = 0; done_cnt = 0; done_cyc = 0; rd_bursts = 0; wr_bursts = 0;
        rd_left = 0; rd_beat = 0; wr_left = 0; resp_cnt = 0; rgnt_cnt = 0; wgnt_cnt = 0;
        rd_seen = 0; wr_seen = 0; prev_hold = 0; reset_hit = 0;
        prev_data = 32'd0; rd2_addr = 32'd0; rd_obs = '0; wr_obs = '0;

        push_expected(v.src, v.dst, v.len);
        src_addr = v.src; dst_addr = v.dst; copy_len = v.len;
        copy_active = 1'b1;

        while (1'b1) begin
            @(posedge clk); #1;
            cyc++;
            idle_inputs();
            if (v.poke && cyc >= 5 && cyc <= 8) begin
                copy_active = 1'b1;
                src_addr = 32'hBAD0_0000; dst_addr = 32'hBAD1_0000; copy_len = 32'd4;
            end

            if (read_request || write_request) begin
                bad = (read_request && (write_request || rd_left > 0 || wr_left > 0 || resp_cnt > 0)) ||
                      (write_request && (rd_left > 0 || wr_left > 0 || resp_cnt > 0));
                check("req_exclusive", {31'd0, bad}, 32'd0);
            end

            if (copy_done) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = cyc;
            end

            // Read slave
            if (read_request) begin
                if (!rd_seen) begin
                    rd_seen = 1; rgnt_cnt = 0; rd_bursts++;
                    rd_obs.addr = read_address; rd_obs.len = read_len;
                    if (rd_bursts == 2) rd2_addr = read_address;
                    if (exp_rd.size() == 0) begin
                        check("rd_unexpected", 32'd1, 32'd0);
                    end else begin
                        bt = exp_rd.pop_front();
                        check("rd_addr", read_address, bt.addr);
                        check("rd_len", {28'd0, read_len}, {28'd0, bt.len});
                    end
                end else begin
                    check("rd_req_hold", {read_len, read_address[27:0]}, {rd_obs.len, rd_obs.addr[27:0]});
                end
                if (rgnt_cnt >= v.gdelay) begin
                    read_gnt = 1'b1; rd_seen = 0;
                    rd_left = int'(rd_obs.len) + 1; rd_beat = 0;
                end else begin
                    rgnt_cnt++;
                end
            end else if (rd_left > 0) begin
                if (v.do_rst && rd_bursts == 2 && rd_beat == 3) begin
                    reset_hit = 1;
                    break;
                end
                if (!(v.rv_gaps && (cyc % 2 == 1))) begin
                    rvalid = 1'b1;
                    read_data = src_word(rd_obs.addr + 32'(4 * rd_beat));
                    rd_beat++; rd_left--;
                end
            end

            // Write slave
            if (write_request) begin
                if (!wr_seen) begin
                    wr_seen = 1; wgnt_cnt = 0; wr_bursts++;
                    wr_obs.addr = write_address; wr_obs.len = write_len;
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected", 32'd1, 32'd0);
                    end else begin
                        bt = exp_wr.pop_front();
                        check("wr_addr", write_address, bt.addr);
                        check("wr_len", {28'd0, write_len}, {28'd0, bt.len});
                    end
                end else begin
                    check("wr_req_hold", {write_len, write_address[27:0]}, {wr_obs.len, wr_obs.addr[27:0]});
                end
                if (wgnt_cnt >= v.gdelay) begin
                    write_gnt = 1'b1; wr_seen = 0;
                    wr_left = int'(wr_obs.len) + 1; prev_hold = 0;
                end else begin
                    wgnt_cnt++;
                end
            end else if (wvalid) begin
                if (prev_hold) check("wdata_hold", write_data, prev_data);
                wready = v.wr_toggle ? (cyc % 2 == 0) : 1'b1;
                if (wr_left == 0) begin
                    check("wvalid_extra", 32'd1, 32'd0);
                    wready = 1'b1;
                end else if (wready) begin
                    if (exp_data.size() == 0) begin
                        check("wdata_unexpected", 32'd1, 32'd0);
                    end else begin
                        ed = exp_data.pop_front();
                        check("wdata", write_data, ed);
                    end
                    wr_left--;
                    if (wr_left == 0) resp_cnt = 2;
                    prev_hold = 0;
                end else begin
                    prev_hold = 1;
                    prev_data = write_data;
                end
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) write_resp = 1'b1;
            end

            // Stray read beats while writing must not touch the buffer.
            if (v.spur && !rvalid && (write_request || wvalid || resp_cnt > 0)) begin
                rvalid = 1'b1;
                read_data = 32'hDEAD_BEEF ^ 32'(cyc);
            end

            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            if (cyc >= 3000) begin
                check("timeout", 32'd1, 32'd0);
                break;
            end
        end

        if (reset_hit) begin
            idle_inputs();
            #2 rst_n = 1'b0;
            #1 check_outputs_zero("rst_mid");
            repeat (2) @(posedge clk);
            #1 check("rst_busy", {31'd0, busy}, 32'd0);
            @(negedge clk) rst_n = 1'b1;
            dn = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (copy_done) dn++;
            end
            check("rst_no_done", 32'(dn), 32'd0);
            check("rst_idle", {31'd0, busy}, 32'd0);
            $display("vec %0d: reset during read burst %0d, beat %0d", k, rd_bursts, rd_beat);
        end else begin
            check("done_pulses", 32'(done_cnt), 32'd1);
            check("idle_after", {31'd0, busy}, 32'd0);
            check("rd_bursts", 32'(rd_bursts), 32'(v.exp_bursts));
            check("wr_bursts", 32'(wr_bursts), 32'(v.exp_bursts));
            check("left_rd", 32'(exp_rd.size()), 32'd0);
            check("left_wr", 32'(exp_wr.size()), 32'd0);
            check("left_data", 32'(exp_data.size()), 32'd0);
            if (v.exp_done_cyc != 0) check("done_latency", 32'(done_cyc), 32'(v.exp_done_cyc));
            if (v.exp_bursts >= 2) check("rd2_addr", rd2_addr, v.exp_rd2);
            $display("vec %0d: src=%08h dst=%08h len=%0d bursts=%0d done_cycle=%0d",
                     k, v.src, v.dst, v.len, rd_bursts, done_cyc);
        end
        exp_rd.delete();
        exp_wr.delete();
        exp_data.delete();
    endtask

    initial begin
        //            src           dst           len     tgl  gap  poke spur rst  gd bursts rd2          done
        vecs[0] = '{32'h0000_1000, 32'h0000_2000, 32'd0,   1'b0,1'b0,1'b0,1'b0,1'b0, 0, 0, 32'h0000_0000, 2};
        vecs[1] = '{32'h0000_1000, 32'h0000_2000, 32'd16,  1'b0,1'b0,1'b0,1'b0,1'b0, 1, 1, 32'h0000_0000, 0};
        vecs[2] = '{32'h0000_1000, 32'h0000_2000, 32'd100, 1'b0,1'b0,1'b0,1'b0,1'b0, 0, 2, 32'h0000_1040, 0};
        vecs[3] = '{32'h0000_1003, 32'h0000_2002, 32'd7,   1'b0,1'b0,1'b0,1'b0,1'b0, 2, 1, 32'h0000_0000, 0};
        vecs[4] = '{32'h0000_1000, 32'h0000_2000, 32'd80,  1'b1,1'b1,1'b0,1'b0,1'b0, 1, 2, 32'h0000_1040, 0};
        vecs[5] = '{32'h0000_1000, 32'h0000_2000, 32'd100, 1'b0,1'b0,1'b1,1'b0,1'b0, 1, 2, 32'h0000_1040, 0};
        vecs[6] = '{32'hFFFF_FFC0, 32'h0000_4000, 32'd128, 1'b0,1'b0,1'b0,1'b0,1'b0, 0, 2, 32'h0000_0000, 0};
        vecs[7] = '{32'h0000_1000, 32'h0000_2000, 32'd128, 1'b0,1'b0,1'b0,1'b0,1'b1, 0, 0, 32'h0000_0000, 0};
        vecs[8] = '{32'h0000_5000, 32'h0000_6000, 32'd40,  1'b0,1'b1,1'b0,1'b0,1'b0, 1, 1, 32'h0000_0000, 0};
        vecs[9] = '{32'h0000_1000, 32'h0000_2000, 32'd200, 1'b1,1'b0,1'b0,1'b1,1'b0, 0, 4, 32'h0000_1040, 0};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_idle", {30'd0, busy, copy_done}, 32'd0);

        for (int k = 0; k < NVEC; k++) begin
            run_vec(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
